pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the 9-bit processor's fetch stage.
- Owns the PC register and the run/halt state machine, and sequences the branch-target lookup table.
- Each cycle it chooses increment, hold (stall), redirect to a table target, or halt, then presents the PC to instruction memory with a valid qualifier.
- It also reports done, an illegal-target error and a run-cycle count to the testbench/top level.

Parameters:
- D, 10, PC / instruction-address width; must match the target table width.
- START_ADDR, 0, PC loaded on start.
- NUM_TARGETS, 19, number of populated table entries; indices >= NUM_TARGETS are illegal.
- CNT_W, 16, cycle counter width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution from START_ADDR.
- stall  in  1  pipeline hold; freezes the PC.
- branch_en  in  1  decoded taken branch/jump for the instruction at prog_ctr.
- halt  in  1  decoded halt for the instruction at prog_ctr.
- lut_idx  in  5  branch target index from the instruction.
- lut_addr  out  5  drives target table addr; combinational copy of lut_idx.
- lut_target  in  D  table output, combinational from lut_addr.
- prog_ctr  out  D  current fetch address.
- fetch_valid  out  1  prog_ctr holds a real instruction this cycle.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  high in DONE.
- bad_target  out  1  sticky; illegal index used on a branch.
- cycle_cnt  out  CNT_W  cycles spent in RUN+FLUSH since the last start.

Behaviour:
- Reset, next edge: state=IDLE, prog_ctr=0, fetch_valid=0, busy=0, done=0, bad_target=0, cycle_cnt=0. Reset overrides everything, including mid-run and mid-FLUSH.
- States: IDLE, RUN, FLUSH, DONE. Outputs are registered, except lut_addr.
- fetch_valid=1 only in RUN. busy=1 in RUN or FLUSH. done=1 only in DONE.
- IDLE or DONE, start=1: prog_ctr<=START_ADDR, cycle_cnt<=0, bad_target<=0, go RUN. The first valid fetch is the next cycle.
- IDLE or DONE, start=0: hold all outputs.
- RUN: start is ignored. Per-cycle priority is stall > halt > branch_en > increment.
  - stall=1: prog_ctr held; halt and branch_en are ignored (they re-present when the stall releases).
  - halt=1: go DONE; prog_ctr held at the halt address.
  - branch_en=1 and lut_idx<NUM_TARGETS: prog_ctr<=lut_target, go FLUSH.
  - branch_en=1 and lut_idx>=NUM_TARGETS: bad_target<=1, go DONE, prog_ctr held.
  - Otherwise: prog_ctr<=prog_ctr+1, modulo 2^D (2^D-1 wraps to 0, no flag).
- FLUSH: always exactly 1 cycle. fetch_valid=0 (bubble); stall, halt, branch_en and start are ignored; prog_ctr holds the target; then go RUN.
- Branch latency: branch_en is sampled at edge N; the target is valid (fetch_valid=1) in the cycle after edge N+1.
- cycle_cnt increments on every edge where the current state is RUN or FLUSH, stall cycles included. It saturates at 2^CNT_W-1 and is frozen in IDLE/DONE.
- Simultaneous halt+branch_en: halt wins; bad_target is not set even if lut_idx is illegal.

Test Plan:
1. Reset, then start at cycle 0 -> prog_ctr 0,1,2,3 on consecutive RUN cycles with fetch_valid=1; cycle_cnt=3 after the 3rd RUN cycle.
2. At prog_ctr=5, branch_en=1, lut_idx=1 (table gives 19) -> next cycle FLUSH with fetch_valid=0 and prog_ctr=19; following cycle RUN with prog_ctr=19, then 20.
3. branch_en=1, lut_idx=16 while stall=1 for 3 cycles -> prog_ctr held; after the stall drops, prog_ctr=202 with one bubble. Then lut_idx=15 -> prog_ctr=2.
4. branch_en=1, lut_idx=25 -> bad_target=1, done=1, busy=0, prog_ctr unchanged; a later start clears bad_target and PC=0.
5. halt and branch_en both high at prog_ctr=40 -> DONE, prog_ctr=40, done=1. Assert Reset during FLUSH in a separate run -> IDLE, prog_ctr=0, all flags 0.
6. Free-run from prog_ctr=1022 with D=10 -> 1023, then 0 with fetch_valid continuous. Force cycle_cnt near 2^16-1 (small CNT_W=4 build) -> it saturates at 15.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the 9-bit processor's fetch stage.
// Owns the PC and the IDLE/RUN/FLUSH/DONE state machine, and drives the
// branch-target table address.
//
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   start               pulse; begin execution from START_ADDR (IDLE/DONE only)
//   stall               freeze the PC (highest priority in RUN)
//   branch_en, halt     decoded branch / halt for the instruction at prog_ctr
//   lut_idx, lut_addr   branch target index in; combinational copy out to table
//   lut_target          table output for lut_addr
//   prog_ctr            current fetch address
//   fetch_valid         prog_ctr is a real instruction (RUN only)
//   busy, done          RUN|FLUSH, DONE
//   bad_target          sticky: branch used an illegal table index
//   cycle_cnt           saturating count of RUN+FLUSH cycles since last start
module pc_sequencer #(
  parameter int D           = 10,
  parameter int START_ADDR  = 0,
  parameter int NUM_TARGETS = 19,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             halt,
  input  logic [4:0]       lut_idx,
  output logic [4:0]       lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             busy,
  output logic             done,
  output logic             bad_target,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [5:0] IDX_LIMIT = 6'(NUM_TARGETS);

  state_t           state, state_nxt;
  logic [D-1:0]     pc_nxt;
  logic             bad_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             idx_legal;

  assign lut_addr  = lut_idx;
  assign idx_legal = ({1'b0, lut_idx} < IDX_LIMIT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    bad_nxt   = bad_target;
    cnt_nxt   = cycle_cnt;

    // Counter advances on every RUN/FLUSH edge (stalls included) and saturates.
    if ((state == S_RUN || state == S_FLUSH) && cycle_cnt != '1)
      cnt_nxt = cycle_cnt + CNT_W'(1);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = D'(START_ADDR);
          bad_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (stall) begin
          state_nxt = S_RUN;
        end else if (halt) begin
          state_nxt = S_DONE;
        end else if (branch_en) begin
          if (idx_legal) begin
            pc_nxt    = lut_target;
            state_nxt = S_FLUSH;
          end else begin
            bad_nxt   = 1'b1;
            state_nxt = S_DONE;
          end
        end else begin
          pc_nxt = prog_ctr + D'(1);
        end
      end
      S_FLUSH: begin
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      prog_ctr    <= '0;
      fetch_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bad_target  <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      prog_ctr    <= pc_nxt;
      fetch_valid <= (state_nxt == S_RUN);
      busy        <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
      done        <= (state_nxt == S_DONE);
      bad_target  <= bad_nxt;
      cycle_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random stimulus.
// Two instances share the inputs: default widths, and a CNT_W=4 build for
// counter saturation. Expected outputs come from a behavioural model and are
// queued by the driver; the monitor pops and compares after each clock edge.
module tb_pc_sequencer;

  localparam int D  = 10;
  localparam int NT = 19;

  logic       Clk = 1'b0;
  logic       Reset, start, stall, branch_en, halt;
  logic [4:0] lut_idx;
  logic [4:0] lut_addr, lut_addr4;
  logic [D-1:0] lut_target, lut_target4;
  logic [D-1:0] prog_ctr, prog_ctr4;
  logic fetch_valid, busy, done, bad_target;
  logic fetch_valid4, busy4, done4, bad_target4;
  logic [15:0] cycle_cnt;
  logic [3:0]  cycle_cnt4;

  logic [D-1:0] tbl [32];

  always #5 Clk = ~Clk;

  always_comb lut_target  = tbl[lut_addr];
  always_comb lut_target4 = tbl[lut_addr4];

  pc_sequencer #(.D(D), .START_ADDR(0), .NUM_TARGETS(NT), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
    .branch_en(branch_en), .halt(halt), .lut_idx(lut_idx),
    .lut_addr(lut_addr), .lut_target(lut_target), .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid), .busy(busy), .done(done),
    .bad_target(bad_target), .cycle_cnt(cycle_cnt)
  );

  pc_sequencer #(.D(D), .START_ADDR(0), .NUM_TARGETS(NT), .CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
    .branch_en(branch_en), .halt(halt), .lut_idx(lut_idx),
    .lut_addr(lut_addr4), .lut_target(lut_target4), .prog_ctr(prog_ctr4),
    .fetch_valid(fetch_valid4), .busy(busy4), .done(done4),
    .bad_target(bad_target4), .cycle_cnt(cycle_cnt4)
  );

  typedef struct {
    int   pc;
    bit   fv;
    bit   bsy;
    bit   dn;
    bit   bad;
    int   cnt;
    int   idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: mode 0=idle,1=running,2=bubble after branch,3=finished
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  bit m_bad  = 0;

  task automatic model_step();
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_bad = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_cnt = 0; m_bad = 0;
      end
    end else if (m_mode == 2) begin
      m_cnt++;
      m_mode = 1;
    end else begin
      m_cnt++;
      if (stall) begin
      end else if (halt) begin
        m_mode = 3;
      end else if (branch_en) begin
        if (int'(lut_idx) < NT) begin
          m_pc = int'(tbl[lut_idx]);
          m_mode = 2;
        end else begin
          m_bad = 1;
          m_mode = 3;
        end
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  // Apply inputs for the coming edge, predict, queue expectation, wait.
  task automatic step(input bit rst, input bit st, input bit stl,
                      input bit br, input bit hlt, input int idx);
    exp_t e;
    Reset = rst; start = st; stall = stl; branch_en = br; halt = hlt;
    lut_idx = 5'(idx);
    model_step();
    e.pc  = m_pc;
    e.fv  = (m_mode == 1);
    e.bsy = (m_mode == 1 || m_mode == 2);
    e.dn  = (m_mode == 3);
    e.bad = m_bad;
    e.cnt = m_cnt;
    e.idx = idx;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 1100 && m_pc != target; n++) idle_step();
  endtask

  // Monitor: compare both instances one time unit after each rising edge.
  initial begin
    exp_t e;
    int sat4, sat16;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        sat16 = (e.cnt > 65535) ? 65535 : e.cnt;
        sat4  = (e.cnt > 15) ? 15 : e.cnt;
        checks++;
        if (int'(prog_ctr) != e.pc || fetch_valid != e.fv || busy != e.bsy ||
            done != e.dn || bad_target != e.bad || int'(cycle_cnt) != sat16) begin
          errors++;
          $display("FAIL cnt16 t=%0t got pc=%0d fv=%0b busy=%0b done=%0b bad=%0b cnt=%0d exp pc=%0d fv=%0b busy=%0b done=%0b bad=%0b cnt=%0d",
                   $time, prog_ctr, fetch_valid, busy, done, bad_target, cycle_cnt,
                   e.pc, e.fv, e.bsy, e.dn, e.bad, sat16);
        end
        checks++;
        if (int'(prog_ctr4) != e.pc || fetch_valid4 != e.fv || busy4 != e.bsy ||
            done4 != e.dn || bad_target4 != e.bad || int'(cycle_cnt4) != sat4) begin
          errors++;
          $display("FAIL cnt4 t=%0t got pc=%0d fv=%0b busy=%0b done=%0b bad=%0b cnt=%0d exp pc=%0d fv=%0b busy=%0b done=%0b bad=%0b cnt=%0d",
                   $time, prog_ctr4, fetch_valid4, busy4, done4, bad_target4, cycle_cnt4,
                   e.pc, e.fv, e.bsy, e.dn, e.bad, sat4);
        end
        checks++;
        if (int'(lut_addr) != e.idx) begin
          errors++;
          $display("FAIL lut_addr t=%0t got %0d exp %0d", $time, lut_addr, e.idx);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = D'((i * 37 + 11) % 1024);
    tbl[1]  = 10'd19;
    tbl[3]  = 10'd1022;
    tbl[15] = 10'd2;
    tbl[16] = 10'd202;

    // Reset, then start: PC 0,1,2,3 ...
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle_step();
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle_step();

    // Branch at PC 5 via index 1 -> 19 with one bubble
    run_to(5);
    step(0, 0, 0, 1, 0, 1);
    idle_step();
    idle_step();

    // Branch held under a 3-cycle stall, then taken -> 202, then -> 2
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 16);
    step(0, 0, 0, 1, 0, 16);
    idle_step();
    step(0, 0, 0, 1, 0, 15);
    idle_step();
    idle_step();

    // Illegal index -> DONE with bad_target; start clears it
    step(0, 0, 0, 1, 0, 25);
    idle_step();
    step(0, 1, 0, 0, 0, 0);
    idle_step();

    // Halt beats an illegal branch at PC 40
    run_to(40);
    step(0, 0, 0, 1, 1, 25);
    idle_step();
    step(0, 1, 0, 1, 1, 25);   // start into RUN; halt/branch ignored on this edge

    // Reset in the middle of a flush
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    idle_step();

    // Wrap from 1022 through 1023 to 0
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) idle_step();

    // Long run to saturate the 4-bit counter, then stall/halt
    for (int i = 0; i < 20; i++) idle_step();
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle_step();

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 59) == 0),
           int'($urandom_range(0, 31)));
    end

    idle_step();
    @(posedge Clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
